// File: rtl/cart_bk_xfer_pkg.sv
// Shared types and constants for the cartridge battery-backup transfer engine.
package cart_bk_xfer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_WAIT  = 3'd1,
        ST_WR_PULSE = 3'd2,
        ST_RD_ISSUE = 3'd3,
        ST_RD_WAIT  = 3'd4,
        ST_RD_HOLD  = 3'd5,
        ST_FIN      = 3'd6
    } xfer_state_t;

    localparam logic [15:0] CRC_POLY       = 16'h1021;
    localparam logic [15:0] CRC_INIT       = 16'hFFFF;
    localparam int          WORDS_PER_MASK = 256;
    localparam int          ADDR_W         = 17;

    // Last word address for a save-size select: (mask+1)*256 - 1, up to 0xFFFF.
    function automatic logic [ADDR_W-1:0] last_addr(input logic [7:0] mask);
        return ((ADDR_W'(mask) + ADDR_W'(1)) * ADDR_W'(WORDS_PER_MASK)) - ADDR_W'(1);
    endfunction

endpackage

// File: rtl/cart_bk_crc16.sv
// One-word-per-cycle CRC-16/CCITT update, high byte first, MSB first.
module cart_bk_crc16
    import cart_bk_xfer_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [15:0] data,
    output logic [15:0] crc_out
);

    logic [15:0] c;

    always_comb begin
        c = crc_in;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ data[i]) begin
                c = {c[14:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/cart_bk_xfer.sv
// Battery-save transfer engine between a host word stream and cartridge RAM.
// Optional CRC over transferred words is built only when CART_BK_CRC_EN is defined.
module cart_bk_xfer
    import cart_bk_xfer_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        start,
    input  logic        dir,
    input  logic        abort,
    input  logic [7:0]  ram_mask_file,
    input  logic        has_save,
    input  logic        s_valid,
    input  logic [15:0] s_data,
    output logic        s_ready,
    output logic        m_valid,
    output logic [15:0] m_data,
    input  logic        m_ready,
    output logic        bk_active,
    output logic        bk_wr,
    output logic [16:0] bk_addr,
    output logic [15:0] bk_data,
    input  logic [15:0] bk_q,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] crc,
    output logic [2:0]  state_dbg
);

    localparam logic [2:0] RD_LAST = 3'(RD_LAT - 1);

    xfer_state_t       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [15:0]       mdata_q, mdata_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              err_q, err_d;

    // Both streams use valid/ready: a word moves on a clock edge where valid and
    // ready are both high; the producer holds data stable until that edge.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        last_d  = last_q;
        wdata_d = wdata_q;
        mdata_d = mdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (abort) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (has_save) begin
                            state_d = dir ? ST_RD_ISSUE : ST_WR_WAIT;
                            err_d   = 1'b0;
                            addr_d  = '0;
                            last_d  = last_addr(ram_mask_file);
                        end else begin
                            state_d = ST_FIN;
                            err_d   = 1'b1;
                        end
                    end
                end
                ST_WR_WAIT: begin
                    if (s_valid) begin
                        wdata_d = s_data;
                        state_d = ST_WR_PULSE;
                    end
                end
                ST_WR_PULSE: begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = (addr_q == last_q) ? ST_FIN : ST_WR_WAIT;
                end
                ST_RD_ISSUE: begin
                    cnt_d   = '0;
                    state_d = ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (cnt_q == RD_LAST) begin
                        mdata_d = bk_q;
                        state_d = ST_RD_HOLD;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                ST_RD_HOLD: begin
                    if (m_ready) begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = (addr_q == last_q) ? ST_FIN : ST_RD_ISSUE;
                    end
                end
                ST_FIN:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            last_q  <= '0;
            wdata_q <= '0;
            mdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            wdata_q <= wdata_d;
            mdata_q <= mdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FIN);
    assign err       = err_q;
    assign bk_active = busy && !done;
    assign bk_wr     = (state_q == ST_WR_PULSE);
    assign s_ready   = (state_q == ST_WR_WAIT);
    assign m_valid   = (state_q == ST_RD_HOLD);
    assign bk_addr   = addr_q;
    assign bk_data   = wdata_q;
    assign m_data    = mdata_q;
    assign state_dbg = state_q;

`ifdef CART_BK_CRC_EN
    logic        crc_clr, crc_upd;
    logic [15:0] crc_word, crc_next;
    logic [15:0] crc_q, crc_d;

    cart_bk_crc16 u_crc (
        .crc_in  (crc_q),
        .data    (crc_word),
        .crc_out (crc_next)
    );

    // The CRC follows exactly the words that reach cram or the host.
    always_comb begin
        crc_clr  = !abort && (state_q == ST_IDLE) && start && has_save;
        crc_upd  = !abort && ((state_q == ST_WR_PULSE) || ((state_q == ST_RD_HOLD) && m_ready));
        crc_word = (state_q == ST_RD_HOLD) ? mdata_q : wdata_q;
        crc_d    = crc_q;
        if (crc_clr) begin
            crc_d = CRC_INIT;
        end else if (crc_upd) begin
            crc_d = crc_next;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;
`else
    assign crc = '0;
`endif

endmodule

// File: tb/tb_cart_bk_xfer.sv
// Self-checking bench for cart_bk_xfer: restore, save, no-save, abort and reset cases.
module tb_cart_bk_xfer;

    localparam int RD_LAT = 2;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        start, dir, abort, has_save;
    logic [7:0]  ram_mask_file;
    logic        s_valid, s_ready;
    logic [15:0] s_data;
    logic        m_valid, m_ready;
    logic [15:0] m_data;
    logic        bk_active, bk_wr;
    logic [16:0] bk_addr;
    logic [15:0] bk_data, bk_q;
    logic        busy, done, err;
    logic [15:0] crc;
    logic [2:0]  state_dbg;

    int          n_checks = 0;
    int          n_errors = 0;
    int          wr_cnt, rd_cnt, done_cnt, act_cnt;
    int          ready_mode = 0;
    logic [32:0] exp_q[$];
    logic [15:0] tb_crc;
    logic [15:0] prev_mdata;
    logic        prev_stall = 1'b0;
    logic [15:0] rd_pipe [RD_LAT];

    cart_bk_xfer #(.RD_LAT(RD_LAT)) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .start         (start),
        .dir           (dir),
        .abort         (abort),
        .ram_mask_file (ram_mask_file),
        .has_save      (has_save),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .m_valid       (m_valid),
        .m_data        (m_data),
        .m_ready       (m_ready),
        .bk_active     (bk_active),
        .bk_wr         (bk_wr),
        .bk_addr       (bk_addr),
        .bk_data       (bk_data),
        .bk_q          (bk_q),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .crc           (crc),
        .state_dbg     (state_dbg)
    );

    // clock / reset
    always #5 clk_sys = ~clk_sys;

    initial begin
        #900000;
        $display("FAIL watchdog: got time limit expected completion");
        $fatal(1, "watchdog expired");
    end

    // cram model: word = ~addr, valid RD_LAT edges after the address
    always @(posedge clk_sys) begin
        rd_pipe[0] <= ~bk_addr[15:0];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bk_q = rd_pipe[RD_LAT-1];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] crc_word(input logic [15:0] crc_in, input logic [15:0] w);
        logic [15:0] c;
        logic [7:0]  bv;
        c = crc_in;
        for (int b = 0; b < 2; b++) begin
            bv = (b == 0) ? w[15:8] : w[7:0];
            c  = c ^ {bv, 8'h00};
            for (int i = 0; i < 8; i++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    function automatic logic [15:0] exp_crc_val();
`ifdef CART_BK_CRC_EN
        return tb_crc;
`else
        return 16'h0000;
`endif
    endfunction

    // scoreboard / monitor
    always @(negedge clk_sys) begin
        if (!reset) begin
            if (bk_wr) begin
                wr_cnt++;
                check("wr_active", bk_active, 1);
                check("wr_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("wr_word", {bk_addr, bk_data}, exp_q.pop_front());
            end
            if (m_valid && prev_stall) check("m_stable", m_data, prev_mdata);
            if (m_valid && m_ready) begin
                rd_cnt++;
                check("rd_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("rd_word", {bk_addr, m_data}, exp_q.pop_front());
            end
            if (done) done_cnt++;
            if (bk_active) act_cnt++;
            prev_stall = m_valid && !m_ready;
            prev_mdata = m_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // m_ready driver: 0 = low, 1 = high, 2 = random
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            case (ready_mode)
                0:       m_ready = 1'b0;
                1:       m_ready = 1'b1;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic clear_stats();
        wr_cnt   = 0;
        rd_cnt   = 0;
        done_cnt = 0;
        act_cnt  = 0;
        exp_q.delete();
        tb_crc   = 16'hFFFF;
    endtask

    task automatic pulse_start(input logic d, input logic [7:0] mask, input logic hs);
        @(posedge clk_sys);
        #1;
        dir           = d;
        ram_mask_file = mask;
        has_save      = hs;
        start         = 1'b1;
        @(posedge clk_sys);
        #1;
        start = 1'b0;
    endtask

    task automatic drive_restore(input int n_words, input bit zero_data);
        for (int k = 0; k < n_words; k++) begin
            int          n;
            logic [15:0] w;
            w = zero_data ? 16'h0000 : (16'(k) ^ 16'hA5A5);
            repeat ($urandom_range(0, 1)) begin
                @(posedge clk_sys);
                #1;
            end
            s_valid = 1'b1;
            s_data  = w;
            n = 0;
            do begin
                @(negedge clk_sys);
                n++;
            end while (!s_ready && n < 20);
            if (!s_ready) begin
                check("s_ready_timeout", s_ready, 1);
                s_valid = 1'b0;
                return;
            end
            exp_q.push_back({17'(k), w});
            tb_crc = crc_word(tb_crc, w);
            @(posedge clk_sys);
            #1;
            s_valid = 1'b0;
        end
    endtask

    task automatic push_save(input int n_words);
        for (int k = 0; k < n_words; k++) begin
            exp_q.push_back({17'(k), ~16'(k)});
            tb_crc = crc_word(tb_crc, ~16'(k));
        end
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk_sys);
            n++;
        end
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        dir = 1'b0;
        abort = 1'b0;
        has_save = 1'b0;
        ram_mask_file = 8'h00;
        s_valid = 1'b0;
        s_data = 16'h0000;
        clear_stats();

        repeat (3) @(negedge clk_sys);
        check("rst_flags", {busy, done, err, bk_active, bk_wr, s_ready, m_valid}, 0);
        check("rst_data", {bk_addr, bk_data, m_data, crc}, 0);
        @(posedge clk_sys);
        #1;
        reset = 1'b0;

        // restore 4096 words of addr ^ 0xA5A5
        clear_stats();
        pulse_start(1'b0, 8'h0F, 1'b1);
        check("t1_busy", busy, 1);
        drive_restore(4096, 1'b0);
        wait_idle(50, "t1");
        repeat (3) @(negedge clk_sys);
        check("t1_wr_cnt", wr_cnt, 4096);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_err", err, 0);
        check("t1_queue", exp_q.size(), 0);
        check("t1_crc", crc, exp_crc_val());

        // start without a battery save
        clear_stats();
        @(posedge clk_sys);
        #1;
        dir = 1'b0;
        ram_mask_file = 8'h00;
        has_save = 1'b0;
        start = 1'b1;
        @(negedge clk_sys);
        check("t2_c1_done", done, 0);
        @(posedge clk_sys);
        #1;
        start = 1'b0;
        @(negedge clk_sys);
        check("t2_c2_done", done, 1);
        check("t2_err", err, 1);
        @(negedge clk_sys);
        check("t2_c3_done", done, 0);
        check("t2_busy", busy, 0);
        repeat (2) @(negedge clk_sys);
        check("t2_wr_cnt", wr_cnt, 0);
        check("t2_active_cnt", act_cnt, 0);
        check("t2_done_cnt", done_cnt, 1);

        // save 1024 words with random m_ready
        clear_stats();
        push_save(1024);
        ready_mode = 2;
        pulse_start(1'b1, 8'h03, 1'b1);
        wait_idle(20000, "t3");
        ready_mode = 0;
        repeat (3) @(negedge clk_sys);
        check("t3_rd_cnt", rd_cnt, 1024);
        check("t3_wr_cnt", wr_cnt, 0);
        check("t3_done_cnt", done_cnt, 1);
        check("t3_err", err, 0);
        check("t3_queue", exp_q.size(), 0);
        check("t3_crc", crc, exp_crc_val());

        // abort after 100 restored words, racing a handshake
        clear_stats();
        pulse_start(1'b0, 8'h0F, 1'b1);
        drive_restore(100, 1'b0);
        @(negedge clk_sys);
        @(posedge clk_sys);
        #1;
        s_valid = 1'b1;
        s_data  = 16'h1234;
        abort   = 1'b1;
        @(negedge clk_sys);
        check("t4_ready", s_ready, 1);
        @(posedge clk_sys);
        #1;
        abort   = 1'b0;
        s_valid = 1'b0;
        @(negedge clk_sys);
        check("t4_busy", busy, 0);
        check("t4_err", err, 1);
        repeat (5) @(negedge clk_sys);
        check("t4_wr_cnt", wr_cnt, 100);
        check("t4_done_cnt", done_cnt, 0);
        check("t4_active", bk_active, 0);
        check("t4_queue", exp_q.size(), 0);

        // single-mask restore of zeros, CRC golden value
        clear_stats();
        pulse_start(1'b0, 8'h00, 1'b1);
        drive_restore(256, 1'b1);
        wait_idle(50, "t5");
        repeat (3) @(negedge clk_sys);
        check("t5_wr_cnt", wr_cnt, 256);
        check("t5_done_cnt", done_cnt, 1);
        check("t5_err", err, 0);
        check("t5_crc", crc, exp_crc_val());

        // reset while holding a save word, then a clean save
        clear_stats();
        push_save(256);
        ready_mode = 1;
        pulse_start(1'b1, 8'h00, 1'b1);
        n = 0;
        while (rd_cnt < 20 && n < 500) begin
            @(negedge clk_sys);
            n++;
        end
        check("t6_progress", rd_cnt >= 20, 1);
        ready_mode = 0;
        n = 0;
        do begin
            @(negedge clk_sys);
            n++;
        end while (!(m_valid && !m_ready) && n < 50);
        check("t6_state", state_dbg, cart_bk_xfer_pkg::ST_RD_HOLD);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_flags", {busy, done, err, bk_active, bk_wr, s_ready, m_valid}, 0);
        check("t6_rst_data", {bk_addr, bk_data, m_data, crc}, 0);
        repeat (2) @(posedge clk_sys);
        #1;
        reset = 1'b0;
        check("t6_no_done", done_cnt, 0);
        clear_stats();
        push_save(256);
        ready_mode = 2;
        pulse_start(1'b1, 8'h00, 1'b1);
        wait_idle(5000, "t6");
        ready_mode = 0;
        repeat (3) @(negedge clk_sys);
        check("t6_rd_cnt", rd_cnt, 256);
        check("t6_done_cnt", done_cnt, 1);
        check("t6_err", err, 0);
        check("t6_queue", exp_q.size(), 0);
        check("t6_crc", crc, exp_crc_val());

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cart_bk_xfer.md
CART_BK_XFER -- requirements
Module: cart_bk_xfer

Interface
REQ-001 SHALL have parameter RD_LAT, default 2, meaning clk_sys cycles from bk_addr stable to bk_q valid (range 1..7).
REQ-002 SHALL have ports: clk_sys  in  1  system clock; reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: start  in  1  one-cycle transfer request; dir  in  1  0=restore (host->cram), 1=save (cram->host); abort  in  1  cancel transfer.
REQ-004 SHALL have ports: ram_mask_file  in  8  save size select; has_save  in  1  cart has a battery save.
REQ-005 SHALL have ports: s_valid  in  1, s_data  in  16, s_ready  out  1; restore word stream from host.
REQ-006 SHALL have ports: m_valid  out  1, m_data  out  16, m_ready  in  1; save word stream to host.
REQ-007 SHALL have ports: bk_active  out  1  owns cram port; bk_wr  out  1; bk_addr  out  17  word address; bk_data  out  16; bk_q  in  16.
REQ-008 SHALL have ports: busy  out  1; done  out  1  one-cycle completion pulse; err  out  1  sticky until next start; crc  out  16.

Function
REQ-009 SHALL compute word count N = (ram_mask_file+1)*256, latched at start; addresses run 0..N-1.
REQ-010 SHALL implement states IDLE, WR_WAIT, WR_PULSE, RD_ISSUE, RD_WAIT, RD_HOLD, FIN.
REQ-011 IDLE: start with has_save=1 -> WR_WAIT (dir=0) or RD_ISSUE (dir=1); clears err, address counter, crc.
REQ-012 start with has_save=0 SHALL go to FIN with err=1 and no bk_wr, no stream handshake.
REQ-013 start while busy SHALL be ignored.
REQ-014 WR_WAIT: s_ready=1; on s_valid&s_ready latch s_data to bk_data -> WR_PULSE.
REQ-015 WR_PULSE: bk_wr=1 for exactly one cycle at current bk_addr; then increment; last word (addr=N-1) -> FIN, else WR_WAIT.
REQ-016 RD_ISSUE: drive bk_addr for one cycle -> RD_WAIT; RD_WAIT counts RD_LAT cycles, then captures bk_q into m_data -> RD_HOLD.
REQ-017 RD_HOLD: m_valid=1, m_data stable until m_ready; on handshake increment address; last word -> FIN, else RD_ISSUE.
REQ-018 FIN: done=1 for one cycle -> IDLE.
REQ-019 bk_active SHALL be 1 in every state except IDLE and FIN; bk_wr SHALL never assert outside WR_PULSE.
REQ-020 busy SHALL equal (state != IDLE).
REQ-021 abort SHALL force IDLE next cycle from any state, set err=1, no done pulse, no further bk_wr; abort has priority over a same-cycle handshake.
REQ-022 s_ready SHALL be 0 and m_valid SHALL be 0 outside WR_WAIT/RD_HOLD respectively.
REQ-023 address counter SHALL be 17 bits; N=65536 reaches 0xFFFF without wrap before FIN.

Reset
REQ-024 On reset: state IDLE; busy, done, err, bk_active, bk_wr, s_ready, m_valid = 0; bk_addr, bk_data, m_data, crc = 0.
REQ-025 Reset mid-transfer SHALL abandon the transfer with no done pulse.

Configuration
REQ-026 With CART_BK_CRC_EN defined, crc SHALL be CRC-16/CCITT (poly 0x1021, init 0xFFFF, MSB-first, high byte then low byte) over every transferred word, updated on the write pulse or read handshake and held after FIN.
REQ-027 Without CART_BK_CRC_EN, crc SHALL be constant 0 and no CRC logic is synthesised.

Structure
REQ-028 Shared package SHALL hold the state enumeration, the CRC polynomial/init constants and the words-per-mask-step constant (256).
REQ-029 A sub-module cart_bk_crc16 (one-word-per-cycle CRC update) SHALL be instantiated only under CART_BK_CRC_EN.

Verification
REQ-030 Restore, ram_mask_file=0x0F, 4096 words of data=addr^0xA5A5 -> 4096 bk_wr pulses, addr 0..0xFFF, one done, err=0.
REQ-031 Save, RD_LAT=2, ram_mask_file=0x03, memory model word=~addr, random m_ready -> 1024 words received in order, m_data stable while stalled.
REQ-032 start with has_save=0 -> done on cycle 2, err=1, zero bk_wr, bk_active never 1.
REQ-033 abort after word 100 of restore -> IDLE next cycle, err=1, no done, exactly 100 bk_wr pulses.
REQ-034 CART_BK_CRC_EN, restore of single-mask (256 words) all 0x0000 -> crc equals golden model value; without macro crc=0.
REQ-035 Reset asserted in RD_HOLD -> all outputs reset values asynchronously; next start runs a full clean transfer.
